// File: rtl/word_serializer_if.sv
// Bundles the parallel-word input handshake and the serial output handshake of the word serializer.
// Carries wires only, so it adds no latency.
// Flow control is valid/ready on both sides: in_valid/in_ready for words, ser_valid/ser_ready for bits.
interface word_serializer_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             ser_out;
    logic             ser_valid;
    logic             ser_last;
    logic             ser_ready;

    // Producer/consumer side: drives words in and accepts bits out.
    modport master (
        output in_data, in_valid, ser_ready,
        input  in_ready, ser_out, ser_valid, ser_last
    );

    // Serializer side.
    modport slave (
        input  in_data, in_valid, ser_ready,
        output in_ready, ser_out, ser_valid, ser_last
    );
endinterface

// File: rtl/word_serializer.sv
// Parallel-in, serial-out word reader with a shifter plus a one-word holding register.
// Latency: a word accepted into an idle block presents its first bit in the cycle after acceptance.
// Backpressure: ser_ready=0 freezes the shifter; in_ready drops only while the holding register is full.
module word_serializer #(
    parameter int WIDTH     = 16,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    word_serializer_if.slave     bus,
    output logic                 busy
);
    localparam int              CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]   LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_reg_q, shift_reg_d;
    logic [WIDTH-1:0] hold_reg_q, hold_reg_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic             hold_full_q, hold_full_d;

    logic             shift_full;
    logic             in_rdy;
    logic             last_bit;
    logic             acc;
    logic             adv;
    logic             fin;

    // State register: synchronous active-low reset discards any word in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            shift_reg_q <= '0;
            hold_reg_q  <= '0;
            bit_cnt_q   <= '0;
            hold_full_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_reg_q <= shift_reg_d;
            hold_reg_q  <= hold_reg_d;
            bit_cnt_q   <= bit_cnt_d;
            hold_full_q <= hold_full_d;
        end
    end

    // Output decode and handshake events; everything here is a function of current state.
    always_comb begin
        shift_full    = (state_q == SHIFT);
        in_rdy        = reset & ~hold_full_q;
        last_bit      = shift_full & (bit_cnt_q == LAST_CNT);
        acc           = bus.in_valid & in_rdy;
        adv           = shift_full & bus.ser_ready;
        fin           = adv & last_bit;
        bus.in_ready  = in_rdy;
        bus.ser_valid = shift_full;
        bus.ser_last  = last_bit;
        bus.ser_out   = shift_full & (MSB_FIRST ? shift_reg_q[WIDTH-1] : shift_reg_q[0]);
        busy          = shift_full | hold_full_q;
    end

    // Next state: finishing a word refills from the holding register first, then from the input.
    always_comb begin
        state_d     = state_q;
        shift_reg_d = shift_reg_q;
        hold_reg_d  = hold_reg_q;
        bit_cnt_d   = bit_cnt_q;
        hold_full_d = hold_full_q;

        if (fin) begin
            bit_cnt_d = '0;
            if (hold_full_q) begin
                shift_reg_d = hold_reg_q;
                hold_full_d = 1'b0;
            end else if (acc) begin
                shift_reg_d = bus.in_data;
            end else begin
                state_d = IDLE;
            end
        end else if (adv) begin
            if (MSB_FIRST) begin
                shift_reg_d = {shift_reg_q[WIDTH-2:0], 1'b0};
            end else begin
                shift_reg_d = {1'b0, shift_reg_q[WIDTH-1:1]};
            end
            bit_cnt_d = bit_cnt_q + CW'(1);
        end else if (!shift_full && acc) begin
            // Bypass: an idle shifter takes the word directly.
            shift_reg_d = bus.in_data;
            bit_cnt_d   = '0;
            state_d     = SHIFT;
        end

        // A word accepted while the shifter stays busy parks in the holding register.
        if (acc && shift_full && !fin) begin
            hold_reg_d  = bus.in_data;
            hold_full_d = 1'b1;
        end
    end
endmodule

// File: tb/tb_word_serializer.sv
module tb_word_serializer;
    logic clk;
    logic reset;
    logic busy_m;
    logic busy_l;

    logic [15:0] id [2];
    logic        iv [2];
    logic        sr [2];

    int checks = 0;
    int errors = 0;

    word_serializer_if #(.WIDTH(16)) bus_m ();
    word_serializer_if #(.WIDTH(16)) bus_l ();

    assign bus_m.in_data   = id[0];
    assign bus_m.in_valid  = iv[0];
    assign bus_m.ser_ready = sr[0];
    assign bus_l.in_data   = id[1];
    assign bus_l.in_valid  = iv[1];
    assign bus_l.ser_ready = sr[1];

    word_serializer #(.WIDTH(16), .MSB_FIRST(1'b1)) dut_m (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_m),
        .busy  (busy_m)
    );

    word_serializer #(.WIDTH(16), .MSB_FIRST(1'b0)) dut_l (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_l),
        .busy  (busy_l)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Output snapshot: {in_ready, ser_valid, ser_last, ser_out, busy}
    function automatic logic [4:0] outs(input int sel);
        if (sel == 0)
            return {bus_m.in_ready, bus_m.ser_valid, bus_m.ser_last, bus_m.ser_out, busy_m};
        return {bus_l.in_ready, bus_l.ser_valid, bus_l.ser_last, bus_l.ser_out, busy_l};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input int sel, input logic [15:0] w);
        logic [4:0] o;
        id[sel] = w;
        iv[sel] = 1'b1;
        sr[sel] = 1'b1;
        #1;
        o = outs(sel);
        chk("accept_ready", {63'd0, o[4]}, 64'd1);
        next();
        iv[sel] = 1'b0;
    endtask

    task automatic collect(input int sel, output logic [15:0] s, output logic [15:0] l,
                           output logic [15:0] v);
        logic [4:0] o;
        s = '0;
        l = '0;
        v = '0;
        sr[sel] = 1'b1;
        for (int i = 0; i < 16; i++) begin
            #1;
            o = outs(sel);
            s = {s[14:0], o[1]};
            l = {l[14:0], o[2]};
            v = {v[14:0], o[3]};
            next();
        end
    endtask

    typedef struct {
        logic [15:0] word;
        int          sel;
        logic [15:0] stream;
    } vec_t;

    typedef struct {
        logic b;
        logic last;
    } mbit_t;

    initial begin
        vec_t        tbl [6];
        logic [15:0] s, l, v;
        logic [4:0]  o;
        logic [47:0] s48, l48;
        logic [15:0] bw [3];
        int          k, vcnt, firstv, lastv, stalls, nbits, fin_cyc, viol, rdy_hi;
        logic        acc_now, prev_stall, prev_out;
        mbit_t       mq[$];
        int          words;
        logic [4:0]  exp_o;
        logic        ev, er;

        tbl[0] = '{16'hA5C3, 0, 16'hA5C3};
        tbl[1] = '{16'h00F1, 1, 16'h8F00};
        tbl[2] = '{16'h1234, 1, 16'h2C48};
        tbl[3] = '{16'h1234, 0, 16'h1234};
        tbl[4] = '{16'h8000, 1, 16'h0001};
        tbl[5] = '{16'h0001, 0, 16'h0001};

        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            iv[i] = 1'b1;
            id[i] = 16'hFFFF;
            sr[i] = 1'b1;
        end

        // Reset held low with in_valid asserted: everything reads 0
        next();
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("reset_outs_m", {59'd0, outs(0)}, 64'd0);
            chk("reset_outs_l", {59'd0, outs(1)}, 64'd0);
            next();
        end
        iv[0] = 1'b0;
        iv[1] = 1'b0;
        reset = 1'b1;
        next();
        #1;
        chk("post_reset_ready", {59'd0, outs(0)}, {59'd0, 5'b10000});
        next();

        // Table-driven single words on both bit orders
        for (int t = 0; t < 6; t++) begin
            accept(tbl[t].sel, tbl[t].word);
            collect(tbl[t].sel, s, l, v);
            chk("tbl_stream", {48'd0, s}, {48'd0, tbl[t].stream});
            chk("tbl_last", {48'd0, l}, 64'h0001);
            chk("tbl_valid", {48'd0, v}, 64'hFFFF);
            #1;
            chk("tbl_idle_after", {59'd0, outs(tbl[t].sel)}, {59'd0, 5'b10000});
            next();
        end

        // Back-to-back words with ser_ready held high
        bw[0] = 16'h0001;
        bw[1] = 16'h8000;
        bw[2] = 16'hFFFF;
        k = 0; vcnt = 0; firstv = -1; lastv = -1; stalls = 0;
        s48 = '0; l48 = '0;
        sr[0] = 1'b1;
        for (int c = 0; c < 50; c++) begin
            if (k < 3) begin
                iv[0] = 1'b1;
                id[0] = bw[k];
            end else begin
                iv[0] = 1'b0;
            end
            #1;
            o = outs(0);
            acc_now = iv[0] & o[4];
            if (iv[0] && !o[4]) stalls++;
            if (o[3]) begin
                s48 = {s48[46:0], o[1]};
                l48 = {l48[46:0], o[2]};
                vcnt++;
                if (firstv < 0) firstv = c;
                lastv = c;
            end
            next();
            if (acc_now) k++;
        end
        iv[0] = 1'b0;
        chk("b2b_stream", {16'd0, s48}, {16'd0, 16'h0001, 16'h8000, 16'hFFFF});
        chk("b2b_last", {16'd0, l48}, 64'h0000_0001_0001_0001);
        chk("b2b_valid_cnt", 64'(vcnt), 64'd48);
        chk("b2b_no_gap", 64'(lastv - firstv), 64'd47);
        chk("b2b_stall_cycles", 64'(stalls), 64'd15);
        #1;
        chk("b2b_idle_after", {59'd0, outs(0)}, {59'd0, 5'b10000});
        next();

        // Backpressure: ser_ready alternates; extra words offered mid-stall
        accept(0, 16'h1234);
        s = '0; l = '0; nbits = 0; fin_cyc = -1; viol = 0; rdy_hi = 0;
        prev_stall = 1'b0; prev_out = 1'b0;
        for (int c = 1; c <= 31; c++) begin
            sr[0] = (c % 2 == 1);
            if (c == 4) begin
                iv[0] = 1'b1;
                id[0] = 16'h5555;
            end else if (c >= 5 && c <= 10) begin
                iv[0] = 1'b1;
                id[0] = 16'hAAAA;
            end else begin
                iv[0] = 1'b0;
            end
            #1;
            o = outs(0);
            if (prev_stall && (o[1] !== prev_out)) viol++;
            if (c == 4) chk("bp_hold_accept", {63'd0, o[4]}, 64'd1);
            if (c >= 5 && c <= 10 && o[4]) rdy_hi++;
            if (o[3] && sr[0]) begin
                s = {s[14:0], o[1]};
                l = {l[14:0], o[2]};
                nbits++;
                if (nbits == 16) fin_cyc = c;
            end
            prev_stall = o[3] & ~sr[0];
            prev_out   = o[1];
            next();
        end
        iv[0] = 1'b0;
        chk("bp_stream", {48'd0, s}, 64'h1234);
        chk("bp_last", {48'd0, l}, 64'h0001);
        chk("bp_fin_cycle", 64'(fin_cyc), 64'd31);
        chk("bp_stable_out", 64'(viol), 64'd0);
        chk("bp_third_blocked", 64'(rdy_hi), 64'd0);
        collect(0, s, l, v);
        chk("bp_held_word", {48'd0, s}, 64'h5555);
        chk("bp_held_last", {48'd0, l}, 64'h0001);
        #1;
        chk("bp_idle_after", {59'd0, outs(0)}, {59'd0, 5'b10000});
        next();

        // Reset in the middle of BEEF with 1111 in the holding register
        accept(0, 16'hBEEF);
        iv[0] = 1'b1;
        id[0] = 16'h1111;
        #1;
        next();
        iv[0] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            next();
        end
        #1;
        chk("mid_hold_full", {59'd0, outs(0) & 5'b11101}, {59'd0, 5'b01001});
        reset = 1'b0;
        next();
        #1;
        chk("mid_reset_outs", {59'd0, outs(0)}, 64'd0);
        reset = 1'b1;
        next();
        accept(0, 16'h0F0F);
        collect(0, s, l, v);
        chk("mid_after_stream", {48'd0, s}, 64'h0F0F);
        chk("mid_after_last", {48'd0, l}, 64'h0001);
        chk("mid_after_valid", {48'd0, v}, 64'hFFFF);
        #1;
        chk("mid_idle_after", {59'd0, outs(0)}, {59'd0, 5'b10000});
        next();

        // Random traffic against a word/bit queue model
        for (int sel = 0; sel < 2; sel++) begin
            reset = 1'b0;
            iv[sel] = 1'b0;
            next();
            reset = 1'b1;
            mq.delete();
            words = 0;
            acc_now = 1'b0;
            for (int c = 0; c < 400; c++) begin
                if (acc_now) iv[sel] = 1'b0;
                if (!iv[sel] && ($urandom_range(9) < 6)) begin
                    iv[sel] = 1'b1;
                    id[sel] = 16'($urandom);
                end
                sr[sel] = ($urandom_range(9) < 7);
                #1;
                ev = (mq.size() > 0);
                er = (words < 2);
                exp_o = {er, ev, ev ? mq[0].last : 1'b0, ev ? mq[0].b : 1'b0, words > 0};
                chk("rand_outs", {59'd0, outs(sel)}, {59'd0, exp_o});
                if (ev && sr[sel]) begin
                    if (mq[0].last) words--;
                    void'(mq.pop_front());
                end
                acc_now = iv[sel] & er;
                if (acc_now) begin
                    for (int b = 0; b < 16; b++) begin
                        mbit_t e;
                        e.b    = (sel == 0) ? id[sel][15 - b] : id[sel][b];
                        e.last = (b == 15);
                        mq.push_back(e);
                    end
                    words++;
                end
                next();
            end
            iv[sel] = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/word_serializer.md
Name: word_serializer

Overview:
- Parallel-in, serial-out reader for 16-bit words held in register banks of the fixed-point divider datapath (quotient and iteration operands).
- Accepts a word on a valid/ready handshake and shifts it out one bit per serial handshake.
- Two-deep buffering (shifter plus holding register) allows back-to-back words with no idle cycle.
- This block forms the read end of the captured-word path.

Parameters:
- WIDTH, 16, word width in bits; must be 2 or more.
- MSB_FIRST, 1, 1 shifts out bit WIDTH-1 first; 0 shifts out bit 0 first.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset; 0 at a rising clk edge resets the block.
- in_data  input  WIDTH  parallel word to serialize.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a word this cycle.
- ser_out  output  1  current serial bit.
- ser_valid  output  1  ser_out holds a valid bit.
- ser_last  output  1  ser_out is the final bit of the word.
- ser_ready  input  1  downstream consumes ser_out this cycle.
- busy  output  1  a word is in the shifter or the holding register.

Behaviour:
- State: shift_reg[WIDTH], bit_cnt[$clog2(WIDTH)], shift_full; hold_reg[WIDTH], hold_full.
- FSM states:
  - IDLE: shift_full=0.
  - SHIFT: shift_full=1.
- Reset (reset=0 at an edge):
  - shift_full=0, hold_full=0, bit_cnt=0, shift_reg=0, hold_reg=0.
  - All outputs read 0, including in_ready.
  - In-flight words are discarded with no partial completion.
- Output decode:
  - in_ready = reset & ~hold_full.
  - ser_valid = shift_full.
  - busy = shift_full | hold_full.
  - ser_out = MSB_FIRST ? shift_reg[WIDTH-1] : shift_reg[0], gated to 0 when ~shift_full.
  - ser_last = shift_full & (bit_cnt == WIDTH-1).
- Events:
  - acc = in_valid & in_ready.
  - adv = ser_valid & ser_ready.
  - fin = adv & ser_last.
- Shifter update, per edge, priority order:
  1. fin & hold_full: shift_reg <= hold_reg, bit_cnt <= 0, hold_full <= 0, shift_full stays 1.
  2. fin & ~hold_full & acc: shift_reg <= in_data, bit_cnt <= 0, shift_full stays 1.
  3. fin & ~hold_full & ~acc: shift_full <= 0, bit_cnt <= 0 (back to IDLE).
  4. adv & ~fin: shift toward the output end by one (MSB_FIRST: left shift; else right shift), bit_cnt <= bit_cnt+1.
  5. ~shift_full & acc: shift_reg <= in_data, bit_cnt <= 0, shift_full <= 1. This is the bypass path; the holding register is not used.
- Holding register update:
  - If acc, and the word is not consumed by rule 2 or rule 5, then hold_reg <= in_data and hold_full <= 1.
  - Rule 1 and acc never coincide, because in_ready=0 whenever hold_full=1.
- Latency: a word accepted at edge N in IDLE presents its first bit in the cycle after edge N.
- Throughput: continuous words with ser_ready=1 give one bit per cycle, with no gap between words.
- The serial side never drops ser_valid mid-word, and ser_out is stable while ser_valid & ~ser_ready.
- in_valid with in_ready=0 has no effect, and the word is not latched; the upstream holds in_data until acceptance.
- Throttling: ser_ready=0 stalls indefinitely with all state frozen, except that a single word may still enter the holding register.

Test Plan:
- Reset:
  - Stimulus: hold reset=0 for 3 cycles with in_valid=1.
  - Response: in_ready, ser_valid, ser_last, ser_out and busy all read 0; nothing latched.
  - Stimulus: release reset.
  - Response: in_ready=1 on the next cycle.
- Single word, MSB_FIRST=1, ser_ready=1:
  - Stimulus: accept 16'hA5C3.
  - Response: ser_out over 16 consecutive cycles reads 1010_0101_1100_0011; ser_last=1 only on the 16th; ser_valid=0 and busy=0 on the following cycle.
- Back-to-back, ser_ready=1:
  - Stimulus: offer 16'h0001, 16'h8000, 16'hFFFF continuously.
  - Response: 48 consecutive ser_valid cycles; ser_last on cycles 16, 32 and 48; in_ready=0 while the holding register is full; bit streams match each word exactly.
- Backpressure:
  - Stimulus: ser_ready toggles 1,0,1,0 while serializing 16'h1234.
  - Response: ser_out holds steady in every ser_ready=0 cycle; 16 bits are delivered in 31 cycles; a second word offered mid-stall is accepted once into the holding register, and a third sees in_ready=0.
- LSB_FIRST (MSB_FIRST=0):
  - Stimulus: accept 16'h00F1.
  - Response: ser_out reads 1,0,0,0,1,1,1,1 then eight 0s; ser_last on the 16th bit.
- Reset mid-operation:
  - Stimulus: assert reset after bit 5 of 16'hBEEF, with the holding register full of 16'h1111.
  - Response: all outputs 0 on the next cycle.
  - Stimulus: after release, accept 16'h0F0F.
  - Response: 0F0F serializes cleanly from bit 0 of the count, with no residue from BEEF or 1111.
